// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - R-type funct encodings handled by the unit (MULT/MULTU/DIV/DIVU,
//     MTHI/MTLO/MFHI/MFLO)
//   - control state enumeration
//   - helper that flags the signed variants
// Optional feature macro: MULDIV_DIV_EN (divider present when defined).
package muldiv_pkg;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
`ifdef MULDIV_DIV_EN
        DIV,
`endif
        FIXUP,
        DONE
    } state_e;

    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == F_MULT) || (f == F_DIV);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's-complement negation.
// Used both to take operand magnitudes and to restore result signs.
// Ports:
//   in_val  [WIDTH-1:0]  value to pass through or negate
//   neg                  1 = output -in_val, 0 = output in_val
//   out_val [WIDTH-1:0]  result
module muldiv_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_val,
    input  logic             neg,
    output logic [WIDTH-1:0] out_val
);

    always_comb begin
        out_val = in_val;
        if (neg) begin
            out_val = '0 - in_val;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO register pair for
// the multicycle MIPS datapath.
//   MULT/MULTU: shift-add, one multiplier bit per cycle.
//   DIV/DIVU  : restoring shift-subtract, one quotient bit per cycle.
//   MTHI/MTLO : write HI/LO from a; done pulses the next cycle.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start, funct      one-cycle request and R-type funct, sampled in IDLE
//   a, b              rs / rt operands
//   busy              high while a multiply/divide is in flight
//   done              one-cycle pulse once HI/LO hold the new result
//   hi, lo            HI/LO registers
//   mf_data           hi when funct is MFHI, otherwise lo (combinational)
//   illegal           one-cycle pulse after a start with unsupported funct
// Optional feature macro: MULDIV_DIV_EN. When undefined the divider is
// absent and DIV/DIVU are treated as unsupported functs.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data,
    output logic             illegal
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_e             state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    // Multiplicand magnitude for MUL, divisor magnitude for DIV.
    logic [WIDTH-1:0]   opnd_q,    opnd_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic               neg_res_q, neg_res_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               illegal_q, illegal_d;

    logic               signed_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     mul_sum;

`ifdef MULDIV_DIV_EN
    logic               neg_rem_q, neg_rem_d;
    logic               is_div_q,  is_div_d;
    logic [WIDTH:0]     div_shl;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
`endif

    assign signed_op = is_signed_op(funct);

    muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (
        .in_val  (a),
        .neg     (signed_op & a[WIDTH-1]),
        .out_val (abs_a)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (
        .in_val  (b),
        .neg     (signed_op & b[WIDTH-1]),
        .out_val (abs_b)
    );

    muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
        .in_val  (acc_q),
        .neg     (neg_res_q),
        .out_val (prod_fix)
    );

    // Add the multiplicand into the upper half when the current multiplier
    // bit (acc LSB) is set; the extra bit keeps the carry for the shift.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (acc_q[0]) begin
            mul_sum = mul_sum + {1'b0, opnd_q};
        end
    end

`ifdef MULDIV_DIV_EN
    muldiv_negate #(.WIDTH(WIDTH)) u_fix_quo (
        .in_val  (acc_q[WIDTH-1:0]),
        .neg     (neg_res_q),
        .out_val (quo_fix)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .in_val  (acc_q[2*WIDTH-1:WIDTH]),
        .neg     (neg_rem_q),
        .out_val (rem_fix)
    );

    // Shift the next dividend bit into the remainder and trial-subtract.
    // The shifted remainder is below 2*divisor, so WIDTH+1 bits suffice and
    // the sign of the trial tells whether to restore.
    always_comb begin
        div_shl   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shl - {1'b0, opnd_q};
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_res_d = neg_res_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
`ifdef MULDIV_DIV_EN
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (funct)
                        F_MULT, F_MULTU: begin
                            state_d   = MUL;
                            cnt_d     = '0;
                            acc_d     = {{WIDTH{1'b0}}, abs_b};
                            opnd_d    = abs_a;
                            neg_res_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                            busy_d    = 1'b1;
`ifdef MULDIV_DIV_EN
                            is_div_d  = 1'b0;
`endif
                        end
`ifdef MULDIV_DIV_EN
                        F_DIV, F_DIVU: begin
                            busy_d = 1'b1;
                            if (b == '0) begin
                                state_d = DONE;
                                lo_d    = '1;
                                hi_d    = a;
                            end else begin
                                state_d   = DIV;
                                cnt_d     = '0;
                                acc_d     = {{WIDTH{1'b0}}, abs_a};
                                opnd_d    = abs_b;
                                neg_res_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_rem_d = signed_op & a[WIDTH-1];
                                is_div_d  = 1'b1;
                            end
                        end
`endif
                        F_MTHI: begin
                            hi_d    = a;
                            state_d = DONE;
                        end
                        F_MTLO: begin
                            lo_d    = a;
                            state_d = DONE;
                        end
                        F_MFHI, F_MFLO: begin
                        end
                        default: begin
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end

            MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIXUP;
                end
            end

`ifdef MULDIV_DIV_EN
            DIV: begin
                if (!div_trial[WIDTH]) begin
                    acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIXUP;
                end
            end
`endif

            FIXUP: begin
                {hi_d, lo_d} = prod_fix;
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end
`endif
                state_d = DONE;
            end

            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_res_q <= neg_res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
`ifdef MULDIV_DIV_EN
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign illegal = illegal_q;
    assign mf_data = (funct == F_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (WIDTH = 32).
// A behavioural model computes HI/LO with plain 64-bit arithmetic and
// tracks the request/done timing as a countdown; a compare process checks
// busy/done/illegal every cycle and hi/lo/mf_data whenever the unit is idle.
// Directed cases pin the model with hand-computed literals; the divider
// cases follow the MULDIV_DIV_EN macro.
module tb_muldiv_unit;

    localparam logic [5:0] T_MFHI  = 6'b010000;
    localparam logic [5:0] T_MTHI  = 6'b010001;
    localparam logic [5:0] T_MFLO  = 6'b010010;
    localparam logic [5:0] T_MTLO  = 6'b010011;
    localparam logic [5:0] T_MULT  = 6'b011000;
    localparam logic [5:0] T_MULTU = 6'b011001;
    localparam logic [5:0] T_DIV   = 6'b011010;
    localparam logic [5:0] T_DIVU  = 6'b011011;
    localparam int         LAT     = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] a, b;
    logic        busy, done, illegal;
    logic [31:0] hi, lo, mf_data;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .funct   (funct),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .mf_data (mf_data),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
    bit          m_busy = 0, m_done = 0, m_illegal = 0;
    int          m_left = 0;
    longint      sa, sb, sq, sr;
    logic [63:0] p, ua, ub;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_illegal = 0; m_left = 0;
        end else begin
            m_done = 0;
            m_illegal = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_busy = 0;
                    m_hi   = r_hi;
                    m_lo   = r_lo;
                end
            end else if (start) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                ua = {32'd0, a};
                ub = {32'd0, b};
                r_hi = m_hi;
                r_lo = m_lo;
                case (funct)
                    T_MULT: begin
                        p = sa * sb;
                        {r_hi, r_lo} = p; m_busy = 1; m_left = LAT;
                    end
                    T_MULTU: begin
                        p = ua * ub;
                        {r_hi, r_lo} = p; m_busy = 1; m_left = LAT;
                    end
`ifdef MULDIV_DIV_EN
                    T_DIV, T_DIVU: begin
                        m_busy = 1;
                        if (b == 0) begin
                            m_hi = a; m_lo = '1; r_hi = a; r_lo = '1; m_left = 1;
                        end else if (funct == T_DIV) begin
                            sq = sa / sb; sr = sa % sb;
                            r_lo = 32'(sq); r_hi = 32'(sr); m_left = LAT;
                        end else begin
                            p = ua / ub; r_lo = p[31:0];
                            p = ua % ub; r_hi = p[31:0];
                            m_left = LAT;
                        end
                    end
`endif
                    T_MTHI: begin m_hi = a; r_hi = a; m_left = 1; end
                    T_MTLO: begin m_lo = a; r_lo = a; m_left = 1; end
                    T_MFHI, T_MFLO: begin end
                    default: m_illegal = 1;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("illegal", 32'(illegal), 32'(m_illegal));
            if (!m_busy) begin
                check("hi", hi, m_hi);
                check("lo", lo, m_lo);
                check("mf_data", mf_data, (funct == T_MFHI) ? m_hi : m_lo);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [5:0] f, input logic [31:0] aa, input logic [31:0] bb);
        @(posedge clk); #1;
        start = 1'b1; funct = f; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic logic [5:0] pick_funct();
        logic [5:0] tbl [10];
        tbl = '{T_MULT, T_MULTU, T_DIV, T_DIVU, T_MTHI, T_MTLO, T_MFHI, T_MFLO, 6'h00, 6'h2a};
        return tbl[$urandom_range(0, 9)];
    endfunction

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    int lat;
    int done_seen;

    initial begin
        reset = 1'b1; start = 1'b0; funct = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_illegal", 32'(illegal), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // MULTU max * 2
        issue(T_MULTU, 32'hFFFF_FFFF, 32'd2);
        check("multu_busy", 32'(busy), 32'h1);
        wait_done(lat);
        check("multu_lat", 32'(lat), 32'(LAT));
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        // MULT -3 * 5
        issue(T_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat);
        check("mult_lat", 32'(lat), 32'(LAT));
        check("mult_busy_at_done", 32'(busy), 32'h0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);

        // MTLO then MFLO readback
        issue(T_MTLO, 32'h0000_ABCD, 32'h0);
        check("mtlo_busy", 32'(busy), 32'h0);
        wait_done(lat);
        check("mtlo_lat", 32'(lat), 32'd1);
        funct = T_MFLO; #1;
        check("mflo_data", mf_data, 32'h0000_ABCD);

        // Second start during a multiply is ignored
        issue(T_MULTU, 32'h10, 32'h20);
        repeat (4) @(posedge clk);
        #1; start = 1'b1; funct = T_MULT; a = 32'd7; b = 32'd9;
        @(posedge clk); #1; start = 1'b0;
        wait_done(lat);
        check("ignored_done", 32'(done), 32'h1);
        check("ignored_hi", hi, 32'h0);
        check("ignored_lo", lo, 32'h200);
        @(posedge clk); #1;
        check("ignored_no_rerun", 32'(busy), 32'h0);

`ifdef MULDIV_DIV_EN
        issue(T_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        check("div_lat", 32'(lat), 32'(LAT));
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        issue(T_DIVU, 32'd100, 32'd7);
        wait_done(lat);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        issue(T_DIVU, 32'h1234, 32'h0);
        wait_done(lat);
        check("div0_lat", 32'(lat), 32'd1);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'h0000_1234);

        issue(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0);
`else
        issue(T_DIV, 32'd5, 32'd1);
        check("nodiv_illegal", 32'(illegal), 32'h1);
        check("nodiv_busy", 32'(busy), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("nodiv_done", 32'(done), 32'h0);
        check("nodiv_hi", hi, 32'h0);
        check("nodiv_lo", lo, 32'h200);
`endif

        // Reset in the middle of a long operation
        issue(T_MTHI, 32'h5555_5555, 32'h0);
        wait_done(lat);
`ifdef MULDIV_DIV_EN
        issue(T_DIVU, 32'hFFFF_0000, 32'd3);
`else
        issue(T_MULTU, 32'hFFFF_0000, 32'd3);
`endif
        repeat (9) @(posedge clk);
        #1; reset = 1'b1;
        #1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("midrst_no_done", 32'(done_seen), 32'h0);

        // Randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 250; i++) begin
            @(posedge clk); #1;
            start = 1'b1; funct = pick_funct(); a = pick_opnd(); b = pick_opnd();
            for (int k = 0; k < 38; k++) begin
                @(posedge clk); #1;
                start = ($urandom_range(0, 9) == 0);
                funct = pick_funct(); a = pick_opnd(); b = pick_opnd();
            end
            start = 1'b0;
        end
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit for the multicycle MIPS datapath, parametrised in operand width. It decodes the R-type funct field for MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO and owns the HI/LO register pair. Control starts an operation with a one-cycle start pulse and holds in its wait state until done. The unit runs beside the ALU and aludec; aludec is unchanged.

Parameters:
WIDTH, 32, operand width and HI/LO width in bits (even, >= 4)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
funct  input  6  R-type funct field, sampled with start
a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
b  input  WIDTH  rt operand (multiplier / divisor)
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when HI/LO hold the new result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
mf_data  output  WIDTH  combinational: hi if funct==MFHI (010000), else lo
illegal  output  1  one-cycle pulse: start accepted with an unsupported funct

Behaviour:
- Reset (async, any state): state=IDLE; hi=0, lo=0, busy=0, done=0, illegal=0; internal counter and shadow regs cleared. Reset mid-operation abandons the operation.
- States: IDLE, MUL, DIV, FIXUP, DONE.
- IDLE + start:
  - MULT 011000 / MULTU 011001 -> MUL. Operands latched; signed ops latch |a|, |b| and the result sign (a[MSB]^b[MSB]).
  - DIV 011010 / DIVU 011011 -> DIV. Signed ops latch |a|, |b|, quotient sign (a^b) and remainder sign (a).
  - DIV/DIVU with b==0 -> DONE directly: lo = all ones, hi = a.
  - MTHI 010001 / MTLO 010011 -> write hi or lo from a; done next cycle; busy stays 0.
  - MFHI / MFLO or any other funct: no state change. Any other funct also pulses illegal next cycle.
- start is ignored while busy; no queuing.
- MUL: shift-add, one multiplier bit per cycle, counter 0..WIDTH-1, 2*WIDTH-bit accumulator. Then FIXUP.
- DIV: restoring shift-subtract, one quotient bit per cycle, WIDTH cycles. Then FIXUP.
- FIXUP: apply two's-complement negation per latched signs (signed ops only); write {hi,lo}. Mul: hi=upper, lo=lower. Div: lo=quotient, hi=remainder. -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Latency: MUL/DIV done exactly WIDTH+2 cycles after the start cycle (start at edge 0, done high after edge WIDTH+2). Divide-by-zero and MTHI/MTLO: done after edge 1.
- hi/lo change only in FIXUP, in divide-by-zero entry, or on MTHI/MTLO; otherwise stable.
- Overflow: signed DIV of most-negative by -1 gives lo = most-negative, hi = 0. No exception.

Optional Feature:
MULDIV_DIV_EN
- Defined: DIV/DIVU supported as above.
- Undefined: DIV state and divider logic are absent. DIV/DIVU behave as unsupported funct: illegal pulse, no done, hi/lo unchanged.

Decomposition:
- Shared package muldiv_pkg: funct constants (F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO) and state enum typedef.
- One sub-module, muldiv_negate: parametrised conditional two's-complement (abs and fixup). Instanced for operands and results.

Test Plan:
- MULTU a=0xFFFFFFFF, b=2 -> done at cycle 34; hi=0x00000001, lo=0xFFFFFFFE.
- MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high cycles 1..33.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> done after 1 cycle; lo=0xFFFFFFFF, hi=0x1234. MTLO a=0xABCD -> lo=0xABCD, mf_data=0xABCD with funct=MFLO.
- Second start with funct=MULT at cycle 5 of a MULTU -> ignored; the first result is unaffected. Reset asserted at cycle 10 of a DIV -> hi=lo=0, busy=0 immediately, no done.
- Compile without MULDIV_DIV_EN: DIV start -> illegal pulse, hi/lo unchanged, busy stays 0.
